xnor_conv_unit: RTL and testbench
=================================

XNOR_CONV_UNIT -- requirements
Module: xnor_conv_unit

Interface
REQ-001 The block SHALL have parameter NO_CH, default 16, meaning bits per window sample (one binarised channel per bit).
REQ-002 The block SHALL have parameter WINDOW, default 3, meaning samples per input window.
REQ-003 The block SHALL have parameter NO_FILT, default 16, meaning output filters, and the output vector width.
REQ-004 The block SHALL define localparams: FA_W = clog2(NO_FILT) (filter address width); POP_W = clog2(WINDOW*NO_CH+1) (popcount/threshold width, 6 at defaults).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port vld_in, input, 1 bit: window valid from the upstream windower.
REQ-008 The block SHALL have port data_in, input, unpacked array [WINDOW-1:0] of NO_CH-bit words: one window, element 0 oldest.
REQ-009 The block SHALL have port rdy_in, output, 1 bit: the block can accept a window.
REQ-010 The block SHALL have port wt_we, input, 1 bit: write enable for weight/threshold memory.
REQ-011 The block SHALL have port wt_addr, input, FA_W bits: filter index written.
REQ-012 The block SHALL have port wt_data, input, WINDOW*NO_CH bits: filter weights; bit k*NO_CH+c pairs with data_in[k][c].
REQ-013 The block SHALL have port th_data, input, POP_W bits: filter threshold written alongside wt_data.
REQ-014 The block SHALL have port vld_out, output, 1 bit: data_out valid.
REQ-015 The block SHALL have port data_out, output, NO_FILT bits: one result bit per filter, bit f = filter f.
REQ-016 The block SHALL have port rdy_out, input, 1 bit: the downstream stage accepts data_out.

Function
REQ-017 The block SHALL implement states IDLE, COMPUTE and OUT; rdy_in SHALL be 1 exactly in IDLE, and vld_out SHALL be 1 exactly in OUT.
REQ-018 In IDLE, when vld_in=1 at a rising edge, the block SHALL register all WINDOW words, clear filter counter f to 0, and enter COMPUTE.
REQ-019 In each COMPUTE cycle, the block SHALL compute pop = popcount(~(window XOR W[f])) and write data_out[f] = (pop >= TH[f]) at the edge, using unsigned POP_W arithmetic with no saturation.
REQ-020 In COMPUTE, f SHALL increment each cycle; after the edge that evaluates f=NO_FILT-1, the block SHALL enter OUT.
REQ-021 Latency: vld_out SHALL rise exactly NO_FILT cycles after the accepting edge; minimum spacing between accepts is NO_FILT+2 cycles.
REQ-022 In OUT, data_out SHALL hold stable until vld_out&rdy_out at an edge, after which the block SHALL return to IDLE; a simultaneous vld_in in that cycle SHALL be ignored because rdy_in=0.
REQ-023 Outside IDLE, vld_in and data_in SHALL be ignored, and no window SHALL be lost or queued.
REQ-024 W/TH storage is NO_FILT entries; a wt_we write SHALL take effect only in IDLE (W[wt_addr]<=wt_data, TH[wt_addr]<=th_data), and wt_we in COMPUTE or OUT SHALL be dropped.
REQ-025 If wt_we and an accepting vld_in occur in the same IDLE cycle, both SHALL take effect, and the subsequent computation SHALL use the new entry.
REQ-026 A threshold of 0 SHALL always yield 1; a threshold greater than WINDOW*NO_CH SHALL always yield 0.

Reset
REQ-027 While rst=0, the block SHALL force state=IDLE, f=0, vld_out=0, data_out=0, all W=0, all TH=0 and the window register=0; rdy_in therefore reads 1.
REQ-028 Assertion of rst mid-COMPUTE or mid-OUT SHALL abort the window with no output; the block SHALL accept a new window on the first edge after release.

Verification
REQ-029 The bench SHALL cover: reset, no writes, one window of random data -> vld_out rises 16 cycles after accept with data_out=16'hFFFF.
REQ-030 The bench SHALL cover: W[0]=all ones, TH[0]=48; window 3x16'hFFFF -> data_out[0]=1; window with one bit cleared -> data_out[0]=0 (pop 47).
REQ-031 The bench SHALL cover: W[3]=0, TH[3]=25; window 3x16'h0000 -> bit3=1 (pop 48); window 3x16'hAAAA -> bit3=0 (pop 24).
REQ-032 The bench SHALL cover: rdy_out held 0 for 5 cycles in OUT -> data_out and vld_out stable, rdy_in=0, vld_in pulses ignored; after rdy_out=1, rdy_in=1 the next cycle.
REQ-033 The bench SHALL cover: wt_we to filter 5 with TH=63 during COMPUTE -> dropped, result bit5 unchanged; the same write in IDLE -> bit5=0 on the next window.
REQ-034 The bench SHALL cover: rst pulsed at COMPUTE cycle 7 -> vld_out=0 and data_out=0 immediately, no vld_out follows, and the next window computes normally with reset weights.

Source files
------------

// File: rtl/xnor_conv_unit.sv
// Binarised convolution: each filter scores XNOR-popcount(window, weights) >= threshold.
// Latency: vld_out rises NO_FILT cycles after the accepting edge (one filter per cycle).
// Backpressure: one window in flight. rdy_in is low from accept until OUT is drained by rdy_out.
//
// Ports:
//   clk, rst (async, active-low)
//   vld_in/rdy_in/data_in     : window input, data_in[0] is the oldest sample
//   wt_we/wt_addr/wt_data/th_data : weight + threshold write port, honoured only in IDLE
//   vld_out/rdy_out/data_out  : one result bit per filter, bit f = filter f
module xnor_conv_unit #(
    parameter int NO_CH   = 16,
    parameter int WINDOW  = 3,
    parameter int NO_FILT = 16,
    localparam int FA_W   = $clog2(NO_FILT),
    localparam int POP_W  = $clog2(WINDOW*NO_CH+1),
    localparam int WB     = WINDOW*NO_CH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld_in,
    input  logic [NO_CH-1:0]   data_in [WINDOW-1:0],
    output logic               rdy_in,
    input  logic               wt_we,
    input  logic [FA_W-1:0]    wt_addr,
    input  logic [WB-1:0]      wt_data,
    input  logic [POP_W-1:0]   th_data,
    output logic               vld_out,
    output logic [NO_FILT-1:0] data_out,
    input  logic               rdy_out
);

    typedef enum logic [1:0] {IDLE, COMPUTE, OUT} state_t;

    state_t           state;
    logic [FA_W-1:0]  f;
    logic [NO_CH-1:0] win_q  [WINDOW-1:0];
    logic [WB-1:0]    w_mem  [NO_FILT];
    logic [POP_W-1:0] th_mem [NO_FILT];

    logic [WB-1:0]    win_flat;
    logic [WB-1:0]    match;
    logic [POP_W-1:0] pop;

    // Flatten so that bit k*NO_CH+c lines up with weight bit k*NO_CH+c.
    always_comb begin
        win_flat = '0;
        for (int k = 0; k < WINDOW; k++) begin
            win_flat[k*NO_CH +: NO_CH] = win_q[k];
        end
        match = ~(win_flat ^ w_mem[f]);
        pop   = '0;
        for (int i = 0; i < WB; i++) begin
            pop = pop + POP_W'(match[i]);
        end
    end

    // Weight/threshold store. Writes outside IDLE are dropped so a window
    // in flight always sees one consistent set of filters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NO_FILT; i++) begin
                w_mem[i]  <= '0;
                th_mem[i] <= '0;
            end
        end else if (wt_we && state == IDLE) begin
            w_mem[wt_addr]  <= wt_data;
            th_mem[wt_addr] <= th_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            f        <= '0;
            rdy_in   <= 1'b1;
            vld_out  <= 1'b0;
            data_out <= '0;
            for (int k = 0; k < WINDOW; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (vld_in) begin
                        for (int k = 0; k < WINDOW; k++) begin
                            win_q[k] <= data_in[k];
                        end
                        f      <= '0;
                        rdy_in <= 1'b0;
                        state  <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    // Threshold 0 always passes; thresholds above WB never pass.
                    data_out[f] <= (pop >= th_mem[f]);
                    if (f == FA_W'(NO_FILT-1)) begin
                        f       <= '0;
                        vld_out <= 1'b1;
                        state   <= OUT;
                    end else begin
                        f <= f + FA_W'(1);
                    end
                end
                OUT: begin
                    if (rdy_out) begin
                        vld_out <= 1'b0;
                        rdy_in  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    f       <= '0;
                    vld_out <= 1'b0;
                    rdy_in  <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xnor_conv_unit.sv
module tb_xnor_conv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld_in;
    logic [15:0] data_in [2:0];
    logic        rdy_in;
    logic        wt_we;
    logic [3:0]  wt_addr;
    logic [47:0] wt_data;
    logic [5:0]  th_data;
    logic        vld_out;
    logic [15:0] data_out;
    logic        rdy_out;

    int checks = 0;
    int errors = 0;
    int lat;

    xnor_conv_unit dut (
        .clk      (clk),
        .rst      (rst),
        .vld_in   (vld_in),
        .data_in  (data_in),
        .rdy_in   (rdy_in),
        .wt_we    (wt_we),
        .wt_addr  (wt_addr),
        .wt_data  (wt_data),
        .th_data  (th_data),
        .vld_out  (vld_out),
        .data_out (data_out),
        .rdy_out  (rdy_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_win(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
        data_in[0] = d0;
        data_in[1] = d1;
        data_in[2] = d2;
    endtask

    task automatic accept_win(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
        set_win(d0, d1, d2);
        vld_in = 1'b1;
        tick();
        vld_in = 1'b0;
        set_win(16'h1234, 16'h5678, 16'h9ABC);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (vld_out !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic consume();
        rdy_out = 1'b1;
        tick();
        rdy_out = 1'b0;
        check("drain_vld_out", vld_out, 0);
        check("drain_rdy_in", rdy_in, 1);
    endtask

    task automatic write_wt(input logic [3:0] a, input logic [47:0] w, input logic [5:0] th);
        wt_we   = 1'b1;
        wt_addr = a;
        wt_data = w;
        th_data = th;
        tick();
        wt_we   = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        vld_in  = 1'b0;
        wt_we   = 1'b0;
        wt_addr = '0;
        wt_data = '0;
        th_data = '0;
        rdy_out = 1'b0;
        set_win(16'h0, 16'h0, 16'h0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rdy_in", rdy_in, 1);
        check("rst_vld_out", vld_out, 0);
        check("rst_data_out", data_out, 0);
        rst = 1'b1;
        tick();

        // Reset weights (all 0, TH 0): every filter passes
        accept_win(16'h3C5A, 16'h9F01, 16'h7E42);
        check("busy_rdy_in", rdy_in, 0);
        wait_out(lat);
        check("lat_default", lat, 16);
        check("default_result", data_out, 16'hFFFF);
        consume();

        // Filter 0: all-ones weights, threshold 48
        write_wt(4'd0, 48'hFFFF_FFFF_FFFF, 6'd48);
        accept_win(16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_out(lat);
        check("lat_f0_full", lat, 16);
        check("f0_pop48", data_out, 16'hFFFF);
        consume();
        accept_win(16'hFFFF, 16'hFFFE, 16'hFFFF);
        wait_out(lat);
        check("f0_pop47", data_out, 16'hFFFE);
        consume();

        // Filter 3: zero weights, threshold 25
        write_wt(4'd3, 48'h0, 6'd25);
        accept_win(16'h0000, 16'h0000, 16'h0000);
        wait_out(lat);
        check("f3_pop48", data_out, 16'hFFFE);
        consume();
        accept_win(16'hAAAA, 16'hAAAA, 16'hAAAA);
        wait_out(lat);
        check("f3_pop24", data_out, 16'hFFF6);
        consume();

        // Output backpressure with vld_in pulses that must be ignored
        accept_win(16'h0000, 16'h0000, 16'h0000);
        wait_out(lat);
        check("bp_lat", lat, 16);
        for (int i = 0; i < 5; i++) begin
            vld_in = i[0];
            set_win(16'hAAAA, 16'hAAAA, 16'hAAAA);
            tick();
            check("bp_vld_out", vld_out, 1);
            check("bp_data_out", data_out, 16'hFFFE);
            check("bp_rdy_in", rdy_in, 0);
        end
        vld_in  = 1'b1;
        rdy_out = 1'b1;
        tick();
        vld_in  = 1'b0;
        rdy_out = 1'b0;
        check("bp_release_rdy_in", rdy_in, 1);
        check("bp_release_vld_out", vld_out, 0);
        repeat (20) tick();
        check("bp_no_accept", vld_out, 0);

        // Weight write during COMPUTE is dropped
        accept_win(16'h0000, 16'h0000, 16'h0000);
        tick();
        tick();
        write_wt(4'd5, 48'h0, 6'd63);
        wait_out(lat);
        check("wr_busy_lat", lat, 13);
        check("wr_busy_dropped", data_out, 16'hFFFE);
        consume();
        write_wt(4'd5, 48'h0, 6'd63);
        accept_win(16'h0000, 16'h0000, 16'h0000);
        wait_out(lat);
        check("wr_idle_applied", data_out, 16'hFFDE);
        consume();

        // Reset in the middle of COMPUTE
        accept_win(16'h0000, 16'h0000, 16'h0000);
        repeat (7) tick();
        rst = 1'b0;
        #1;
        check("abort_vld_out", vld_out, 0);
        check("abort_data_out", data_out, 0);
        check("abort_rdy_in", rdy_in, 1);
        @(negedge clk);
        @(negedge clk);
        check("abort_hold_data", data_out, 0);
        rst = 1'b1;
        accept_win(16'hAAAA, 16'hAAAA, 16'hAAAA);
        wait_out(lat);
        check("post_rst_lat", lat, 16);
        check("post_rst_result", data_out, 16'hFFFF);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
